// File: rtl/parking_gate_ctrl.sv
// Four-slot car park controller: owns the slot-empty bitmap and sequences the
// entry and exit barriers, committing occupancy only once a car has passed.
//
// Ports:
//   CLK, RST_N   clock (posedge) and asynchronous active-low reset
//   entry_req    car waiting at the entry barrier (level)
//   exit_req     car waiting at the exit barrier (level)
//   exit_slot    slot being vacated, sampled together with exit_req
//   entry_pass   car has cleared the entry barrier
//   exit_pass    car has cleared the exit barrier
//   entry_gate   registered, 1 = entry barrier open
//   exit_gate    registered, 1 = exit barrier open
//   E            slot-empty bitmap, bit i = 1 means slot i free
//   location     lowest-index free slot (decoded from E)
//   capacity     number of free slots (decoded from E)
//   full         no free slot (decoded from E)
//   err          registered one-cycle pulse on timeout or invalid exit
module parking_gate_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 1000,
   parameter int unsigned NUM_SLOTS      = 4,
   localparam int unsigned LOC_W = $clog2(NUM_SLOTS),
   localparam int unsigned CAP_W = $clog2(NUM_SLOTS + 1)
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             entry_req,
   input  logic             exit_req,
   input  logic [LOC_W-1:0] exit_slot,
   input  logic             entry_pass,
   input  logic             exit_pass,
   output logic             entry_gate,
   output logic             exit_gate,
   output logic [NUM_SLOTS-1:0] E,
   output logic [LOC_W-1:0] location,
   output logic [CAP_W-1:0] capacity,
   output logic             full,
   output logic             err
);

   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      ENTRY_OPEN = 2'd1,
      EXIT_OPEN  = 2'd2,
      HOLD       = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [NUM_SLOTS-1:0] e_q, e_d;
   logic [LOC_W-1:0]     rsv_q, rsv_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 entry_gate_d, exit_gate_d, err_d;

   logic [CAP_W-1:0]     free_cnt;
   logic [LOC_W-1:0]     low_free;
   logic                 none_free;

   // Popcount and lowest-free-slot decode of the occupancy register.
   always_comb begin
      free_cnt = '0;
      low_free = '0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         free_cnt = free_cnt + CAP_W'(e_q[i]);
         if (e_q[i]) low_free = LOC_W'(i);
      end
   end

   assign none_free = (e_q == '0);
   assign E         = e_q;
   assign capacity  = free_cnt;
   assign location  = low_free;
   assign full      = none_free;

   // Next-state, occupancy commit and gate control.
   always_comb begin
      state_d      = state_q;
      e_d          = e_q;
      rsv_d        = rsv_q;
      cnt_d        = cnt_q;
      entry_gate_d = entry_gate;
      exit_gate_d  = exit_gate;
      err_d        = 1'b0;

      case (state_q)
         IDLE: begin
            // Exit wins over entry: it frees space rather than consuming it.
            if (exit_req) begin
               if (!e_q[exit_slot]) begin
                  rsv_d       = exit_slot;
                  exit_gate_d = 1'b1;
                  cnt_d       = '0;
                  state_d     = EXIT_OPEN;
               end else begin
                  err_d   = 1'b1;
                  state_d = HOLD;
               end
            end else if (entry_req && !none_free) begin
               rsv_d        = low_free;
               entry_gate_d = 1'b1;
               cnt_d        = '0;
               state_d      = ENTRY_OPEN;
            end
         end

         ENTRY_OPEN: begin
            // A pass in the timeout cycle still counts as a pass.
            if (entry_pass) begin
               e_d[rsv_q]   = 1'b0;
               entry_gate_d = 1'b0;
               state_d      = HOLD;
            end else if (cnt_q == CNT_LAST) begin
               entry_gate_d = 1'b0;
               err_d        = 1'b1;
               state_d      = HOLD;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         EXIT_OPEN: begin
            if (exit_pass) begin
               e_d[rsv_q]  = 1'b1;
               exit_gate_d = 1'b0;
               state_d     = HOLD;
            end else if (cnt_q == CNT_LAST) begin
               exit_gate_d = 1'b0;
               err_d       = 1'b1;
               state_d     = HOLD;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         HOLD: begin
            // Wait for both requests to drop so a lingering level is served once.
            entry_gate_d = 1'b0;
            exit_gate_d  = 1'b0;
            if (!entry_req && !exit_req) state_d = IDLE;
         end

         default: begin
            entry_gate_d = 1'b0;
            exit_gate_d  = 1'b0;
            state_d      = IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q    <= IDLE;
         e_q        <= '1;
         rsv_q      <= '0;
         cnt_q      <= '0;
         entry_gate <= 1'b0;
         exit_gate  <= 1'b0;
         err        <= 1'b0;
      end else begin
         state_q    <= state_d;
         e_q        <= e_d;
         rsv_q      <= rsv_d;
         cnt_q      <= cnt_d;
         entry_gate <= entry_gate_d;
         exit_gate  <= exit_gate_d;
         err        <= err_d;
      end
   end

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Self-checking bench for parking_gate_ctrl: a directed vector table, hand
// sequences for multi-cycle corners, and randomized traffic against a
// transaction-level car-park model.
module tb_parking_gate_ctrl;

   localparam int unsigned TO = 8;

   logic       CLK;
   logic       RST_N;
   logic       entry_req, exit_req, entry_pass, exit_pass;
   logic [1:0] exit_slot;
   logic       entry_gate, exit_gate, full, err;
   logic [3:0] E;
   logic [1:0] location;
   logic [2:0] capacity;

   parking_gate_ctrl #(.TIMEOUT_CYCLES(TO), .NUM_SLOTS(4)) dut (
      .CLK(CLK), .RST_N(RST_N),
      .entry_req(entry_req), .exit_req(exit_req), .exit_slot(exit_slot),
      .entry_pass(entry_pass), .exit_pass(exit_pass),
      .entry_gate(entry_gate), .exit_gate(exit_gate),
      .E(E), .location(location), .capacity(capacity), .full(full), .err(err)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (car-park transactions) ----------------
   // phase: 0 waiting for a car, 1 entry barrier up, 2 exit barrier up,
   //        3 car served, waiting for requests to drop
   int         m_phase;
   logic [3:0] m_free;
   int         m_slot;
   int         m_up_cycles;
   bit         m_err;

   function automatic int free_count(input logic [3:0] f);
      int n = 0;
      for (int i = 0; i < 4; i++) if (f[i]) n++;
      return n;
   endfunction

   function automatic int lowest_free(input logic [3:0] f);
      for (int i = 0; i < 4; i++) if (f[i]) return i;
      return 0;
   endfunction

   task automatic model_reset();
      m_phase = 0; m_free = 4'hF; m_slot = 0; m_up_cycles = 0; m_err = 0;
   endtask

   task automatic model_step();
      bit passed;
      m_err = 0;
      case (m_phase)
         0: begin
            if (exit_req) begin
               if (!m_free[exit_slot]) begin
                  m_phase = 2; m_slot = int'(exit_slot); m_up_cycles = 1;
               end else begin
                  m_err = 1; m_phase = 3;
               end
            end else if (entry_req && free_count(m_free) > 0) begin
               m_phase = 1; m_slot = lowest_free(m_free); m_up_cycles = 1;
            end
         end
         1, 2: begin
            passed = (m_phase == 1) ? entry_pass : exit_pass;
            if (passed) begin
               m_free[m_slot] = (m_phase == 2);
               m_phase = 3;
            end else if (m_up_cycles == int'(TO)) begin
               m_err = 1; m_phase = 3;
            end else begin
               m_up_cycles++;
            end
         end
         default: if (!entry_req && !exit_req) m_phase = 0;
      endcase
   endtask

   task automatic compare_all();
      chk("entry_gate", int'(entry_gate), int'(m_phase == 1));
      chk("exit_gate",  int'(exit_gate),  int'(m_phase == 2));
      chk("E",          int'(E),          int'(m_free));
      chk("capacity",   int'(capacity),   free_count(m_free));
      chk("location",   int'(location),   lowest_free(m_free));
      chk("full",       int'(full),       int'(m_free == 4'h0));
      chk("err",        int'(err),        int'(m_err));
   endtask

   task automatic cycle();
      model_step();
      @(posedge CLK); #1;
      compare_all();
   endtask

   task automatic clear_inputs();
      entry_req = 0; exit_req = 0; exit_slot = 2'd0; entry_pass = 0; exit_pass = 0;
   endtask

   task automatic reset_dut();
      clear_inputs();
      RST_N = 1'b0;
      #2;
      chk("rst_E", int'(E), 15);
      chk("rst_capacity", int'(capacity), 4);
      chk("rst_location", int'(location), 0);
      chk("rst_full", int'(full), 0);
      chk("rst_entry_gate", int'(entry_gate), 0);
      chk("rst_exit_gate", int'(exit_gate), 0);
      chk("rst_err", int'(err), 0);
      @(posedge CLK); #1;
      RST_N = 1'b1;
      model_reset();
   endtask

   task automatic do_entry(input int wait_cycles);
      entry_req = 1; cycle(); entry_req = 0;
      repeat (wait_cycles) cycle();
      entry_pass = 1; cycle(); entry_pass = 0;
      cycle();
   endtask

   task automatic do_exit(input logic [1:0] slot);
      exit_req = 1; exit_slot = slot; cycle(); exit_req = 0;
      exit_pass = 1; cycle(); exit_pass = 0;
      cycle();
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic       en_req, ex_req;
      logic [1:0] slot;
      logic       en_pass, ex_pass;
      logic       exp_eg, exp_xg;
      logic [3:0] exp_e;
      logic       exp_err;
   } vec_t;

   function automatic vec_t mk(input logic a, input logic b, input logic [1:0] s,
                               input logic c, input logic d, input logic eg,
                               input logic xg, input logic [3:0] e, input logic r);
      vec_t v;
      v.en_req = a; v.ex_req = b; v.slot = s; v.en_pass = c; v.ex_pass = d;
      v.exp_eg = eg; v.exp_xg = xg; v.exp_e = e; v.exp_err = r;
      return v;
   endfunction

   vec_t tbl[17];

   initial begin
      int gate_hi, err_cnt;

      // After reset: entry, pass 5 cycles after opening, bad exit, good exit
      // with lingering request, then entry with a stray exit_pass.
      tbl[0]  = mk(0,0,2'd0,0,0, 0,0,4'hF,0);
      tbl[1]  = mk(1,0,2'd0,0,0, 1,0,4'hF,0);
      tbl[2]  = mk(0,0,2'd0,0,0, 1,0,4'hF,0);
      tbl[3]  = mk(0,0,2'd0,0,0, 1,0,4'hF,0);
      tbl[4]  = mk(0,0,2'd0,0,0, 1,0,4'hF,0);
      tbl[5]  = mk(0,0,2'd0,0,0, 1,0,4'hF,0);
      tbl[6]  = mk(0,0,2'd0,1,0, 0,0,4'hE,0);
      tbl[7]  = mk(0,0,2'd0,0,0, 0,0,4'hE,0);
      tbl[8]  = mk(0,1,2'd3,0,0, 0,0,4'hE,1);
      tbl[9]  = mk(0,0,2'd0,0,0, 0,0,4'hE,0);
      tbl[10] = mk(0,1,2'd0,0,0, 0,1,4'hE,0);
      tbl[11] = mk(0,1,2'd0,0,1, 0,0,4'hF,0);
      tbl[12] = mk(1,1,2'd0,0,0, 0,0,4'hF,0);
      tbl[13] = mk(1,0,2'd0,0,0, 0,0,4'hF,0);
      tbl[14] = mk(0,0,2'd0,0,0, 0,0,4'hF,0);
      tbl[15] = mk(1,0,2'd0,0,0, 1,0,4'hF,0);
      tbl[16] = mk(0,0,2'd0,1,1, 0,0,4'hE,0);

      RST_N = 1'b1;
      clear_inputs();
      #1;
      reset_dut();

      for (int i = 0; i < 17; i++) begin
         entry_req = tbl[i].en_req; exit_req = tbl[i].ex_req; exit_slot = tbl[i].slot;
         entry_pass = tbl[i].en_pass; exit_pass = tbl[i].ex_pass;
         @(posedge CLK); #1;
         chk($sformatf("tbl%0d_entry_gate", i), int'(entry_gate), int'(tbl[i].exp_eg));
         chk($sformatf("tbl%0d_exit_gate", i), int'(exit_gate), int'(tbl[i].exp_xg));
         chk($sformatf("tbl%0d_E", i), int'(E), int'(tbl[i].exp_e));
         chk($sformatf("tbl%0d_capacity", i), int'(capacity), free_count(tbl[i].exp_e));
         chk($sformatf("tbl%0d_location", i), int'(location), lowest_free(tbl[i].exp_e));
         chk($sformatf("tbl%0d_full", i), int'(full), int'(tbl[i].exp_e == 4'h0));
         chk($sformatf("tbl%0d_err", i), int'(err), int'(tbl[i].exp_err));
      end

      // Fill the park, then a fifth car is refused silently.
      reset_dut();
      repeat (4) do_entry(2);
      chk("fill_E", int'(E), 0);
      chk("fill_full", int'(full), 1);
      chk("fill_capacity", int'(capacity), 0);
      entry_req = 1;
      repeat (3) cycle();
      chk("fifth_entry_gate", int'(entry_gate), 0);
      chk("fifth_err", int'(err), 0);
      entry_req = 0; cycle();

      // Vacate slot 2 from full, then refill it.
      do_exit(2'd2);
      chk("vacate2_E", int'(E), 4);
      chk("vacate2_capacity", int'(capacity), 1);
      chk("vacate2_location", int'(location), 2);
      do_entry(1);
      chk("refill_E", int'(E), 0);

      // Simultaneous requests: exit served first, entry only after release.
      reset_dut();
      do_entry(0);
      entry_req = 1; exit_req = 1; exit_slot = 2'd0;
      cycle();
      chk("prio_exit_gate", int'(exit_gate), 1);
      chk("prio_entry_gate", int'(entry_gate), 0);
      exit_pass = 1; cycle(); exit_pass = 0; exit_req = 0;
      repeat (3) cycle();
      chk("prio_hold_entry_gate", int'(entry_gate), 0);
      entry_req = 0; cycle();
      entry_req = 1; cycle();
      chk("prio_late_entry_gate", int'(entry_gate), 1);
      entry_req = 0; entry_pass = 1; cycle(); entry_pass = 0; cycle();

      // Invalid exit of an empty slot.
      exit_req = 1; exit_slot = 2'd3; cycle();
      chk("bad_exit_err", int'(err), 1);
      chk("bad_exit_gate", int'(exit_gate), 0);
      exit_req = 0; cycle();
      chk("bad_exit_err_clear", int'(err), 0);

      // Entry timeout: gate up exactly TO cycles, one err pulse, E unchanged.
      gate_hi = 0; err_cnt = 0;
      entry_req = 1; cycle(); entry_req = 0;
      if (entry_gate) gate_hi++;
      repeat (TO + 3) begin
         cycle();
         if (entry_gate) gate_hi++;
         if (err) err_cnt++;
      end
      chk("timeout_gate_cycles", gate_hi, int'(TO));
      chk("timeout_err_pulses", err_cnt, 1);
      chk("timeout_E", int'(E), 14);

      // Pass in the timeout cycle counts as a pass, no error.
      entry_req = 1; cycle(); entry_req = 0;
      repeat (TO - 1) cycle();
      entry_pass = 1; cycle(); entry_pass = 0;
      chk("late_pass_err", int'(err), 0);
      chk("late_pass_E", int'(E), 12);
      cycle();

      // Reset while the entry barrier is up.
      entry_req = 1; cycle(); entry_req = 0;
      chk("midrst_pre_gate", int'(entry_gate), 1);
      RST_N = 1'b0; #1;
      chk("midrst_entry_gate", int'(entry_gate), 0);
      chk("midrst_E", int'(E), 15);
      @(posedge CLK); #1;
      RST_N = 1'b1;
      model_reset();
      cycle();

      // Randomized traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         entry_req  = ($urandom_range(0, 3) == 0);
         exit_req   = ($urandom_range(0, 4) == 0);
         exit_slot  = 2'($urandom_range(0, 3));
         entry_pass = ($urandom_range(0, 5) == 0);
         exit_pass  = ($urandom_range(0, 5) == 0);
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/parking_gate_ctrl.md
Name: parking_gate_ctrl

Overview:
- Controls the four-slot car park: owns the slot-empty bitmap and sequences the entry and exit barrier gates.
- Accepts one entry or exit request at a time and commits occupancy only when the car has physically passed.
- Drives `location`, `capacity` and `E` straight into the 7-segment digit multiplexer, which shows slot/capacity, or "FULL" when E==4'b0000.

Parameters:
- TIMEOUT_CYCLES, 1000, cycles a gate stays open waiting for a pass sensor before aborting (>=2).
- NUM_SLOTS, 4, slot count; fixed at 4 (E/location/capacity widths depend on it).

Ports:
- CLK  in  1  system clock, all logic on posedge
- RST_N  in  1  asynchronous active-low reset
- entry_req  in  1  car waiting at entry (level, pre-synchronised)
- exit_req  in  1  car waiting at exit (level, pre-synchronised)
- exit_slot  in  2  slot index the exiting car vacates; sampled with exit_req
- entry_pass  in  1  car has cleared entry gate (pulse or level)
- exit_pass  in  1  car has cleared exit gate (pulse or level)
- entry_gate  out  1  1 = entry barrier open
- exit_gate  out  1  1 = exit barrier open
- E  out  4  slot-empty bitmap, bit i = 1 means slot i free
- location  out  2  lowest-index free slot (next assigned slot)
- capacity  out  3  number of free slots, 0..4
- full  out  1  1 when E==4'b0000
- err  out  1  one-cycle pulse on timeout or invalid exit

Behaviour:
- Reset (async, RST_N=0):
  - E=4'b1111, capacity=3'd4, location=2'd0, full=0.
  - entry_gate=0, exit_gate=0, err=0, state=IDLE, timeout counter=0.
  - Reset mid-operation closes both gates and discards any pending reservation.
- Derived outputs (combinational from the E register, valid the same cycle E changes):
  - capacity = popcount(E).
  - location = index of the lowest set bit of E; 2'd0 when E==0.
  - full = (E==0).
- FSM states: IDLE, ENTRY_OPEN, EXIT_OPEN, HOLD.
- IDLE:
  - exit_req=1 and E[exit_slot]==0 (slot occupied): latch exit_slot into `rsv`, exit_gate<=1, cnt<=0, go EXIT_OPEN.
  - exit_req=1 and E[exit_slot]==1 (slot already empty): err pulse, no gate, go HOLD.
  - Else entry_req=1 and full==0: latch `location` into `rsv`, entry_gate<=1, cnt<=0, go ENTRY_OPEN.
  - entry_req=1 while full: stay IDLE, gate closed, no err. The display shows FULL.
  - Exit has priority when both requests are high, because an exit frees space.
- ENTRY_OPEN:
  - entry_pass=1: E[rsv]<=0 (capacity drops 1 the next cycle), entry_gate<=0, go HOLD.
  - Else cnt==TIMEOUT_CYCLES-1: entry_gate<=0, err pulse, E unchanged, go HOLD.
  - Else cnt<=cnt+1.
- EXIT_OPEN:
  - Same as ENTRY_OPEN, with exit_pass, exit_gate, and commit E[rsv]<=1.
  - Commit never overflows: capacity stays <=4 because rsv was verified occupied.
- HOLD: wait until entry_req==0 and exit_req==0, then go IDLE. One request yields at most one gate cycle, so a lingering request is never double-counted.
- Gate latency: request sampled at edge N, gate high after edge N; gate low the edge after the pass sensor is sampled high.
- The pass sensor of the non-active gate is ignored.
- A pass sensor asserted in the same cycle as the timeout counts as a pass, with no err.
- Counter width is clog2(TIMEOUT_CYCLES); it saturates and never wraps.
- err is high for exactly one cycle per event.
- Only one gate is open at any time. E changes only at a pass commit.

Test Plan:
- Reset → E=1111, capacity=4, location=0, full=0, both gates 0, err=0.
- entry_req=1, entry_pass pulse 5 cycles after gate opens, release req → entry_gate high 5 cycles, then E=1110, capacity=3, location=1, FSM back in IDLE.
- Four complete entries → E=0000, full=1, capacity=0. A fifth entry_req keeps entry_gate=0 and err=0.
- From full, exit_req with exit_slot=2 plus exit_pass → E=0100, capacity=1, location=2. A following entry refills slot 2.
- entry_req and exit_req(slot 0, occupied) rise in the same cycle → exit_gate opens first, entry_gate stays 0. Entry is served only after the HOLD release and a new entry_req.
- Two error cases:
  - exit_req with exit_slot=3 while E[3]=1 → err pulse 1 cycle, no gate, E unchanged.
  - Entry with no pass for TIMEOUT_CYCLES → gate closes, err pulse, E unchanged.
- RST_N asserted while entry_gate=1 → gate drops immediately and E returns to 1111.
